perf_counter_bank: RTL and testbench
====================================

# perf_counter_bank

Parametrised bank of event/cycle counters for processor datapath instrumentation: the multi-channel successor to the single stop-on-enable-drop cycle counter. Each channel has its own counting mode, synchronous clear, and sticky overflow flag. A snapshot strobe freezes all channels coherently into shadow registers, which are read back one channel at a time through a registered read port.

## Interface
- WIDTH, 16, counter and read-data width in bits (2..32)
- CHANNELS, 4, number of independent counters (1..16)
- SEL_W, 2, channel-select width; must satisfy 2**SEL_W >= CHANNELS
- clock  in  1  sole clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low; asserting it immediately forces the reset state
- event  in  CHANNELS  per-channel event/enable qualifier
- clear  in  CHANNELS  per-channel synchronous clear
- cfg_we  in  1  mode write strobe
- cfg_ch  in  SEL_W  channel targeted by cfg_we
- cfg_mode  in  2  mode value written on cfg_we
- snap  in  1  copy all live counters into the shadow registers
- rd_sel  in  SEL_W  shadow channel to read
- rd_data  out  WIDTH  registered shadow[rd_sel]
- rd_stopped  out  1  registered: channel rd_sel is in STOPPED
- overflow  out  CHANNELS  sticky per-channel overflow flags

## Operation
- Modes:
  - 00 OFF: hold.
  - 01 FREE: +1 every cycle.
  - 10 EVENT: +1 on each cycle with event[ch]=1.
  - 11 UNTIL: +1 each cycle while event[ch]=1; stops permanently on the first cycle with event[ch]=0.
- Per-channel FSM states: IDLE, COUNTING, STOPPED.
  - IDLE: entered when the mode is OFF.
  - COUNTING: entered on a write of any non-OFF mode, or on clear when the mode is non-OFF.
  - COUNTING -> STOPPED: only in UNTIL mode, at the edge where event[ch]=0. No increment occurs on that edge.
  - STOPPED: holds count and state. Exits only on clear[ch] or on cfg_we to that channel.
- Reset values: every counter, shadow and overflow flag = 0; every mode = OFF; every state = IDLE; rd_data = 0; rd_stopped = 0.
- Arithmetic: unsigned, WIDTH bits.
  - The increment out of all-ones follows the Configuration rule below.
  - overflow[ch] is set on that same edge and stays set until clear[ch] or reset.
- cfg_ch >= CHANNELS: the write is ignored.
- rd_sel >= CHANNELS: rd_data = 0 and rd_stopped = 0.
- Simultaneous events on the same edge:
  - clear[ch] together with an increment: clear wins; the counter becomes 0 and overflow[ch] is cleared.
  - clear[ch] together with cfg_we to ch: the new mode is applied and the counter is cleared.
  - snap together with clear[ch]: the shadow captures the pre-clear value.
  - snap together with an increment: the shadow captures the pre-increment value, i.e. the value visible before the edge.
- Reset mid-count: all state returns to reset values asynchronously. Counting resumes only after a mode write.

## Timing
- Increment, clear, mode write and FSM transitions all take effect at the edge on which the inputs are sampled.
- A mode write at edge N produces its first increment at edge N+1.
- snap sampled at edge N loads the shadow at edge N. rd_data reflects the new shadow at edge N+1.
- Read latency: rd_data and rd_stopped update 1 cycle after rd_sel is sampled. No handshake is needed; the read port may change every cycle.
- Reset release is synchronised by the integrator. The block does not act on any edge where reset is low.

## Configuration
- PERF_SATURATE_EN
  - Defined: counters saturate at 2**WIDTH-1 and hold there. overflow[ch] is set on the first attempted increment past the maximum.
  - Undefined (default): counters wrap to 0. overflow[ch] is set on the wrap edge.
- Mode, FSM and read behaviour are identical in both builds.

## Test plan
- Reset then FREE on ch0 (cfg_we, cfg_ch=0, cfg_mode=01); 10 cycles later pulse snap; rd_sel=0 -> rd_data=10 on the cycle after the shadow loads; other channels read 0.
- UNTIL on ch1 with event[1]=1 for 7 cycles, then 0, then 1 again for 5 cycles:
  - snap -> rd_data=7 and rd_stopped=1.
  - pulse clear[1] -> state returns to COUNTING, counter restarts from 0.
- EVENT on ch2 with event[2] toggling every cycle for 20 cycles -> count = 10. clear[2] on the same edge as an event -> count = 0.
- WIDTH=4, FREE on ch3 for 17 cycles:
  - Without PERF_SATURATE_EN -> value 1, overflow[3]=1.
  - With PERF_SATURATE_EN -> value 15, overflow[3]=1.
- Drive reset low for part of a cycle mid-count on all channels -> outputs 0 immediately; all modes OFF; no counting until a mode write.
- snap and clear[0] on the same edge with ch0 at 5 -> shadow reads 5 and live counter = 0. cfg_ch=5 with CHANNELS=4 -> no state change.

Source files
------------

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: per-channel OFF/FREE/EVENT/UNTIL counters with sticky overflow, coherent snapshot and registered readback.
// Define PERF_SATURATE_EN to saturate at all-ones instead of wrapping.
module perf_counter_bank #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] events,
  input  logic [CHANNELS-1:0] clear,
  input  logic                cfg_we,
  input  logic [SEL_W-1:0]    cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic                snap,
  input  logic [SEL_W-1:0]    rd_sel,
  output logic [WIDTH-1:0]    rd_data,
  output logic                rd_stopped,
  output logic [CHANNELS-1:0] overflow
);
  typedef enum logic [1:0] {IDLE, COUNTING, STOPPED} state_t;
  localparam logic [1:0] OFF = 2'b00, FREE = 2'b01, UNTIL = 2'b11;
  logic [WIDTH-1:0] cnt [CHANNELS];
  logic [WIDTH-1:0] shadow [CHANNELS];
  logic [1:0] mode [CHANNELS];
  state_t st [CHANNELS];
  logic [CHANNELS-1:0] wr, inc, stop;
  logic [WIDTH-1:0] rd_mux;
  logic rd_stop_mux;
  always_comb begin
    wr = '0;
    inc = '0;
    stop = '0;
    rd_mux = '0;
    rd_stop_mux = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr[i] = cfg_we && cfg_ch == SEL_W'(i);
      inc[i] = st[i] == COUNTING && (mode[i] == FREE || (mode[i][1] && events[i]));
      stop[i] = st[i] == COUNTING && mode[i] == UNTIL && !events[i];
      rd_mux = rd_sel == SEL_W'(i) ? shadow[i] : rd_mux;
      rd_stop_mux = rd_sel == SEL_W'(i) ? st[i] == STOPPED : rd_stop_mux;
    end
  end
  // A mode write restarts the FSM but never increments on its own edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
        shadow[i] <= '0;
        mode[i] <= OFF;
        st[i] <= IDLE;
      end
      overflow <= '0;
      rd_data <= '0;
      rd_stopped <= 1'b0;
    end else begin
      rd_data <= rd_mux;
      rd_stopped <= rd_stop_mux;
      for (int i = 0; i < CHANNELS; i++) begin
        if (snap) shadow[i] <= cnt[i];
        if (wr[i]) mode[i] <= cfg_mode;
        if (wr[i] || clear[i]) st[i] <= ((wr[i] ? cfg_mode : mode[i]) == OFF) ? IDLE : COUNTING;
        else if (stop[i]) st[i] <= STOPPED;
        if (clear[i]) begin
          cnt[i] <= '0;
          overflow[i] <= 1'b0;
        end else if (inc[i] && !wr[i]) begin
`ifdef PERF_SATURATE_EN
          if (!(&cnt[i])) cnt[i] <= cnt[i] + 1'b1;
`else
          cnt[i] <= cnt[i] + 1'b1;
`endif
          if (&cnt[i]) overflow[i] <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: directed scenarios plus randomized traffic against a behavioural counter model.
module tb_perf_counter_bank;
  localparam int W = 4, CH = 4, SW = 3, MAX = 15;
  logic clock = 1'b0, reset = 1'b0;
  logic [CH-1:0] events = '0, clear = '0;
  logic cfg_we = 1'b0, snap = 1'b0;
  logic [SW-1:0] cfg_ch = '0, rd_sel = '0;
  logic [1:0] cfg_mode = '0;
  logic [W-1:0] rd_data;
  logic rd_stopped;
  logic [CH-1:0] overflow;
  int errors = 0, checks = 0;
  int m_cnt [CH];
  int m_shadow [CH];
  int m_mode [CH];
  bit m_stopped [CH];
  logic [CH-1:0] m_ovf;
  logic [W-1:0] exp_rd;
  logic exp_stp;

  perf_counter_bank #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW)) dut (
    .clock(clock), .reset(reset), .events(events), .clear(clear), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .snap(snap), .rd_sel(rd_sel),
    .rd_data(rd_data), .rd_stopped(rd_stopped), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_cnt[c] = 0;
      m_shadow[c] = 0;
      m_mode[c] = 0;
      m_stopped[c] = 0;
    end
    m_ovf = '0;
  endtask

  // Applies the counting rules to the inputs about to be sampled.
  task automatic model_edge();
    exp_rd = (rd_sel < CH) ? W'(m_shadow[rd_sel]) : '0;
    exp_stp = (rd_sel < CH) ? m_stopped[rd_sel] : 1'b0;
    for (int c = 0; c < CH; c++) begin
      bit wrc;
      wrc = cfg_we && int'(cfg_ch) == c;
      if (snap) m_shadow[c] = m_cnt[c];
      if (wrc) m_mode[c] = int'(cfg_mode);
      if (clear[c]) begin
        m_cnt[c] = 0;
        m_ovf[c] = 1'b0;
      end
      if (wrc || clear[c]) m_stopped[c] = 0;
      else if (m_mode[c] != 0 && !m_stopped[c]) begin
        if (m_mode[c] == 3 && !events[c]) m_stopped[c] = 1;
        else if (m_mode[c] == 1 || events[c]) begin
          if (m_cnt[c] == MAX) begin
            m_ovf[c] = 1'b1;
`ifndef PERF_SATURATE_EN
            m_cnt[c] = 0;
`endif
          end else m_cnt[c] = m_cnt[c] + 1;
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic write_mode(input int ch, input logic [1:0] m);
    cfg_we = 1'b1;
    cfg_ch = SW'(ch);
    cfg_mode = m;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got=%0d exp=0", rd_data); end
    checks++;
    if (rd_stopped !== 1'b0) begin errors++; $display("FAIL reset_rd_stopped got=%b exp=0", rd_stopped); end
    checks++;
    if (overflow !== '0) begin errors++; $display("FAIL reset_overflow got=%b exp=0000", overflow); end
  endtask

  task automatic test_free();
    write_mode(0, 2'b01);
    repeat (10) tick();
    snap = 1'b1;
    rd_sel = 0;
    tick();
    snap = 1'b0;
    tick();
    checks++;
    if (rd_data !== 4'd10) begin errors++; $display("FAIL free_ch0 got=%0d exp=10", rd_data); end
    for (int c = 1; c < CH; c++) begin
      rd_sel = SW'(c);
      tick();
      checks++;
      if (rd_data !== '0) begin errors++; $display("FAIL free_other_ch%0d got=%0d exp=0", c, rd_data); end
    end
  endtask

  task automatic test_until();
    events[1] = 1'b1;
    write_mode(1, 2'b11);
    repeat (7) tick();
    events[1] = 1'b0;
    tick();
    events[1] = 1'b1;
    repeat (5) tick();
    snap = 1'b1;
    rd_sel = 1;
    tick();
    snap = 1'b0;
    tick();
    checks++;
    if (rd_data !== 4'd7) begin errors++; $display("FAIL until_count got=%0d exp=7", rd_data); end
    checks++;
    if (rd_stopped !== 1'b1) begin errors++; $display("FAIL until_stopped got=%b exp=1", rd_stopped); end
    clear[1] = 1'b1;
    tick();
    clear[1] = 1'b0;
    snap = 1'b1;
    tick();
    snap = 1'b0;
    tick();
    checks++;
    if (rd_data !== 4'd0) begin errors++; $display("FAIL until_clear_count got=%0d exp=0", rd_data); end
    checks++;
    if (rd_stopped !== 1'b0) begin errors++; $display("FAIL until_clear_stopped got=%b exp=0", rd_stopped); end
    snap = 1'b1;
    tick();
    snap = 1'b0;
    tick();
    checks++;
    if (rd_data !== 4'd2) begin errors++; $display("FAIL until_restart got=%0d exp=2", rd_data); end
    events[1] = 1'b0;
  endtask

  task automatic test_event();
    write_mode(2, 2'b10);
    for (int i = 0; i < 20; i++) begin
      events[2] = (i % 2 == 0);
      tick();
    end
    events[2] = 1'b0;
    snap = 1'b1;
    rd_sel = 2;
    tick();
    snap = 1'b0;
    tick();
    checks++;
    if (rd_data !== 4'd10) begin errors++; $display("FAIL event_count got=%0d exp=10", rd_data); end
    clear[2] = 1'b1;
    events[2] = 1'b1;
    tick();
    clear[2] = 1'b0;
    events[2] = 1'b0;
    snap = 1'b1;
    tick();
    snap = 1'b0;
    tick();
    checks++;
    if (rd_data !== 4'd0) begin errors++; $display("FAIL event_clear_wins got=%0d exp=0", rd_data); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] want;
`ifdef PERF_SATURATE_EN
    want = 4'd15;
`else
    want = 4'd1;
`endif
    write_mode(3, 2'b01);
    repeat (17) tick();
    snap = 1'b1;
    rd_sel = 3;
    tick();
    snap = 1'b0;
    tick();
    checks++;
    if (rd_data !== want) begin errors++; $display("FAIL overflow_value got=%0d exp=%0d", rd_data, want); end
    checks++;
    if (overflow[3] !== 1'b1) begin errors++; $display("FAIL overflow_flag got=%b exp=1", overflow[3]); end
  endtask

  task automatic test_reset_mid();
    events = '1;
    for (int c = 0; c < CH; c++) write_mode(c, 2'b01);
    repeat (3) tick();
    reset = 1'b0;
    #1;
    checks++;
    if (rd_data !== '0) begin errors++; $display("FAIL midreset_rd_data got=%0d exp=0", rd_data); end
    checks++;
    if (overflow !== '0) begin errors++; $display("FAIL midreset_overflow got=%b exp=0000", overflow); end
    checks++;
    if (rd_stopped !== 1'b0) begin errors++; $display("FAIL midreset_rd_stopped got=%b exp=0", rd_stopped); end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    repeat (5) tick();
    snap = 1'b1;
    tick();
    snap = 1'b0;
    for (int c = 0; c < CH; c++) begin
      rd_sel = SW'(c);
      tick();
      checks++;
      if (rd_data !== '0) begin errors++; $display("FAIL midreset_nocount_ch%0d got=%0d exp=0", c, rd_data); end
    end
    events = '0;
  endtask

  task automatic test_snap_clear();
    write_mode(0, 2'b01);
    repeat (5) tick();
    snap = 1'b1;
    clear[0] = 1'b1;
    tick();
    clear[0] = 1'b0;
    rd_sel = 0;
    tick();
    snap = 1'b0;
    checks++;
    if (rd_data !== 4'd5) begin errors++; $display("FAIL snapclear_shadow got=%0d exp=5", rd_data); end
    tick();
    checks++;
    if (rd_data !== 4'd0) begin errors++; $display("FAIL snapclear_live got=%0d exp=0", rd_data); end
    write_mode(5, 2'b01);
    repeat (3) tick();
    snap = 1'b1;
    tick();
    snap = 1'b0;
    rd_sel = 1;
    tick();
    checks++;
    if (rd_data !== '0) begin errors++; $display("FAIL badch_alias got=%0d exp=0", rd_data); end
    rd_sel = 5;
    tick();
    checks++;
    if (rd_data !== '0 || rd_stopped !== 1'b0) begin
      errors++;
      $display("FAIL badch_read got=%0d/%b exp=0/0", rd_data, rd_stopped);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      events = CH'($urandom);
      for (int c = 0; c < CH; c++) clear[c] = ($urandom_range(15) == 0);
      cfg_we = ($urandom_range(7) == 0);
      cfg_ch = SW'($urandom_range(7));
      cfg_mode = 2'($urandom_range(3));
      snap = ($urandom_range(3) == 0);
      rd_sel = SW'($urandom_range(7));
      tick();
      checks++;
      if (rd_data !== exp_rd || rd_stopped !== exp_stp || overflow !== m_ovf) begin
        errors++;
        $display("FAIL random_cycle%0d got=%0d/%b/%b exp=%0d/%b/%b", n, rd_data, rd_stopped, overflow,
                 exp_rd, exp_stp, m_ovf);
      end
    end
    events = '0;
    clear = '0;
    cfg_we = 1'b0;
    snap = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    test_reset();
    test_free();
    test_until();
    test_event();
    test_overflow();
    test_reset_mid();
    test_snap_clear();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
